// File: rtl/hmm_pkg.sv
// rtl/hmm_pkg.sv - shared constants, FSM states and helpers for the HMM sequence generator
package hmm_pkg;

    localparam logic [31:0] LFSR_MASK = 32'hA300_0000;
    localparam int          PROB_ONE  = 1 << 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DRAW_OBS,
        EMIT,
        DRAW_ST,
        FINISH
    } hmm_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/hmm_cat_sampler.sv
// rtl/hmm_cat_sampler.sv - categorical draw: first index whose cumulative threshold exceeds r
module hmm_cat_sampler
    import hmm_pkg::*;
#(
    parameter int M  = 3,
    parameter int P  = 16,
    localparam int IW = idx_width(M)
) (
    input  logic [P-1:0] r,
    input  logic [P:0]   cum [M],
    output logic [IW-1:0] idx
);

    logic found;

    // Priority scan; falls back to the last index when no threshold qualifies.
    always_comb begin
        idx   = IW'(M - 1);
        found = 1'b0;
        for (int m = 0; m < M; m++) begin
            if (!found && ({1'b0, r} < cum[m])) begin
                idx   = IW'(m);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hmm_seq_gen.sv
// rtl/hmm_seq_gen.sv - HMM state-path sampler and observation streamer
module hmm_seq_gen
    import hmm_pkg::*;
#(
    parameter int          N    = 16,
    parameter int          I    = 3,
    parameter int          K    = 3,
    parameter int          P    = 16,
    parameter logic [31:0] SEED = 32'h1ACE_B00C,
    localparam int         LW   = cnt_width(N),
    localparam int         SW   = idx_width(I),
    localparam int         OW   = idx_width(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] length,
    input  logic          seed_load,
    input  logic [31:0]   seed,
    input  logic [P:0]    cumC [I],
    input  logic [P:0]    cumA [I*I],
    input  logic [P:0]    cumB [I*K],
    output logic [OW-1:0] obs_out,
    output logic          obs_valid,
    input  logic          obs_ready,
    output logic [SW-1:0] state_path [N],
    output logic          busy,
    output logic          done
);

    hmm_state_e    state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] t_q, t_d;
    logic [SW-1:0] s_q, s_d;
    logic [OW-1:0] obs_q, obs_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [SW-1:0] path_q [N];
    logic [SW-1:0] path_d [N];

    logic [P:0]    st_row [I];
    logic [P:0]    ob_row [K];
    logic [SW-1:0] st_idx;
    logic [OW-1:0] ob_idx;
    logic [LW-1:0] eff_len;

    assign eff_len = (length > LW'(N)) ? LW'(N) : length;

    // INIT draws from the initial distribution, DRAW_ST from the current state's transition row.
    always_comb begin
        for (int j = 0; j < I; j++) begin
            st_row[j] = cumC[j];
            if (state_q != INIT) begin
                st_row[j] = cumA[j];
                for (int i = 0; i < I; i++) begin
                    if (s_q == SW'(i)) st_row[j] = cumA[i*I + j];
                end
            end
        end
        for (int j = 0; j < K; j++) begin
            ob_row[j] = cumB[j];
            for (int i = 0; i < I; i++) begin
                if (s_q == SW'(i)) ob_row[j] = cumB[i*K + j];
            end
        end
    end

    hmm_cat_sampler #(.M(I), .P(P)) u_state_sampler (
        .r   (lfsr_q[P-1:0]),
        .cum (st_row),
        .idx (st_idx)
    );

    hmm_cat_sampler #(.M(K), .P(P)) u_obs_sampler (
        .r   (lfsr_q[P-1:0]),
        .cum (ob_row),
        .idx (ob_idx)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        len_d   = len_q;
        t_d     = t_q;
        s_d     = s_q;
        obs_d   = obs_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        path_d  = path_q;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 32'd0) ? SEED : seed;
                end else if (start) begin
                    if (eff_len == '0) begin
                        state_d = FINISH;
                    end else begin
                        len_d   = eff_len;
                        t_d     = '0;
                        busy_d  = 1'b1;
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                s_d     = st_idx;
                lfsr_d  = lfsr_step(lfsr_q);
                state_d = DRAW_OBS;
            end
            DRAW_OBS: begin
                obs_d   = ob_idx;
                valid_d = 1'b1;
                lfsr_d  = lfsr_step(lfsr_q);
                state_d = EMIT;
            end
            EMIT: begin
                if (valid_q && obs_ready) begin
                    for (int i = 0; i < N; i++) begin
                        if (t_q == LW'(i)) path_d[i] = s_q;
                    end
                    valid_d = 1'b0;
                    if (t_q == len_q - LW'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = DRAW_ST;
                    end
                end
            end
            DRAW_ST: begin
                s_d     = st_idx;
                lfsr_d  = lfsr_step(lfsr_q);
                t_d     = t_q + LW'(1);
                state_d = DRAW_OBS;
            end
            FINISH: begin
                // A zero-length request enters with done low; raise it before allowing the exit.
                if (!done_q) begin
                    done_d = 1'b1;
                end else if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            len_q   <= '0;
            t_q     <= '0;
            s_q     <= '0;
            obs_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N; i++) path_q[i] <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            len_q   <= len_d;
            t_q     <= t_d;
            s_q     <= s_d;
            obs_q   <= obs_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            path_q  <= path_d;
        end
    end

    assign obs_out    = obs_q;
    assign obs_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_path = path_q;

endmodule

// File: tb/tb_hmm_seq_gen.sv
// tb/tb_hmm_seq_gen.sv - directed and randomized checks of hmm_seq_gen against a sequence model
module tb_hmm_seq_gen;

    localparam int          N    = 16;
    localparam int          I    = 3;
    localparam int          K    = 3;
    localparam int          P    = 16;
    localparam logic [31:0] SEED = 32'h1ACE_B00C;
    localparam int          ONE  = 65536;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  length;
    logic        seed_load;
    logic [31:0] seed;
    logic [16:0] cumC [I];
    logic [16:0] cumA [I*I];
    logic [16:0] cumB [I*K];
    logic [1:0]  obs_out;
    logic        obs_valid;
    logic        obs_ready;
    logic [1:0]  state_path [N];
    logic        busy;
    logic        done;

    hmm_seq_gen #(.N(N), .I(I), .K(K), .P(P), .SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .length     (length),
        .seed_load  (seed_load),
        .seed       (seed),
        .cumC       (cumC),
        .cumA       (cumA),
        .cumB       (cumB),
        .obs_out    (obs_out),
        .obs_valid  (obs_valid),
        .obs_ready  (obs_ready),
        .state_path (state_path),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state: generator LFSR, expected stream and expected stored path.
    logic [31:0] m_lfsr;
    int          exp_obs [$];
    int          exp_path [N];

    // Per-run observations.
    int got [$];
    int n_hs, first_v, done_c, last_h, stall_seen, stall_obs;
    int seq_a [$];
    int chain_exp [5] = '{1, 2, 0, 1, 2};

    task automatic check(input string tag, input longint observed, input longint expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int draw();
        int r;
        r = int'(m_lfsr[15:0]);
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 32'hA300_0000;
        else           m_lfsr = m_lfsr >> 1;
        return r;
    endfunction

    function automatic int pick(input int r, input int c0, input int c1, input int c2);
        if (r < c0) return 0;
        if (r < c1) return 1;
        if (r < c2) return 2;
        return 2;
    endfunction

    task automatic model_run(input int len);
        int l, s, o;
        l = (len > N) ? N : len;
        exp_obs.delete();
        if (l == 0) return;
        s = pick(draw(), cumC[0], cumC[1], cumC[2]);
        for (int t = 0; t < l; t++) begin
            if (t > 0) s = pick(draw(), cumA[s*3], cumA[s*3+1], cumA[s*3+2]);
            o = pick(draw(), cumB[s*3], cumB[s*3+1], cumB[s*3+2]);
            exp_obs.push_back(o);
            exp_path[t] = s;
        end
    endtask

    function automatic longint pack_dut_path();
        longint v = 0;
        for (int i = 0; i < N; i++) v |= longint'(state_path[i]) << (2*i);
        return v;
    endfunction

    function automatic longint pack_exp_path();
        longint v = 0;
        for (int i = 0; i < N; i++) v |= longint'(exp_path[i] & 3) << (2*i);
        return v;
    endfunction

    // mode 0: ready high, 1: random ready, 2: hold ready low 4 cycles on symbol 1.
    task automatic run(input int len, input int mode, input int abort_after);
        int  hs, stall_cnt, c0;
        bit  fin;
        got.delete();
        hs = 0; stall_cnt = 0; fin = 0;
        first_v = -1; done_c = -1; last_h = -1; stall_seen = 0; stall_obs = -1;
        length = 5'(len);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0    = cyc;
        obs_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(negedge clk);
            if (obs_valid && first_v < 0) first_v = cyc - c0;
            if (obs_valid && !obs_ready && hs == 1) begin
                stall_seen++;
                stall_obs = int'(obs_out);
            end
            if (obs_valid && obs_ready) begin
                got.push_back(int'(obs_out));
                last_h = cyc - c0;
                hs++;
            end
            if (done) begin
                fin    = 1;
                done_c = cyc - c0;
            end
            if (abort_after > 0 && hs == abort_after) fin = 1;
            @(posedge clk); #1;
            case (mode)
                1: obs_ready = 1'($urandom_range(0, 1));
                2: begin
                    obs_ready = !(hs == 1 && obs_valid && stall_cnt < 4);
                    if (!obs_ready) stall_cnt++;
                end
                default: obs_ready = 1'b1;
            endcase
        end
        if (!fin) check("run_timeout", 0, 1);
        n_hs = hs;
    endtask

    task automatic check_run(input string tag, input int len);
        int l;
        l = (len > N) ? N : len;
        check({tag, "_handshakes"}, n_hs, l);
        for (int i = 0; i < l; i++)
            check($sformatf("%s_obs%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_obs[i]);
        check({tag, "_path"}, pack_dut_path(), pack_exp_path());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_abort_valid", obs_valid, 0);
        check("reset_abort_busy", busy, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        obs_ready = 1'b1;
        m_lfsr    = SEED;
        for (int i = 0; i < N; i++) exp_path[i] = 0;
    endtask

    task automatic load_seed(input logic [31:0] v);
        seed_load = 1'b1;
        seed      = v;
        start     = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        start     = 1'b0;
        m_lfsr    = (v == 32'd0) ? SEED : v;
    endtask

    task automatic set_chain();
        cumC = '{0, ONE, ONE};
        cumA = '{0, ONE, ONE,   0, 0, ONE,   ONE, ONE, ONE};
        cumB = '{ONE, ONE, ONE,   0, ONE, ONE,   0, 0, ONE};
    endtask

    task automatic set_uniform();
        cumC = '{21845, 43690, ONE};
        for (int i = 0; i < I; i++) begin
            cumA[i*3] = 21845; cumA[i*3+1] = 43690; cumA[i*3+2] = ONE;
            cumB[i*3] = 21845; cumB[i*3+1] = 43690; cumB[i*3+2] = ONE;
        end
    endtask

    task automatic rand_row(output logic [16:0] c0, output logic [16:0] c1, output logic [16:0] c2);
        int a, b, tmp;
        if ($urandom_range(0, 3) == 0) begin
            c0 = 17'($urandom_range(0, ONE));
            c1 = 17'($urandom_range(0, ONE));
            c2 = 17'($urandom_range(0, ONE));
        end else begin
            a = $urandom_range(0, ONE);
            b = $urandom_range(0, ONE);
            if (a > b) begin tmp = a; a = b; b = tmp; end
            c0 = 17'(a); c1 = 17'(b); c2 = 17'(ONE);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; length = '0; seed_load = 1'b0; seed = '0; obs_ready = 1'b1;
        for (int i = 0; i < I; i++) cumC[i] = '0;
        for (int i = 0; i < I*I; i++) cumA[i] = '0;
        for (int i = 0; i < I*K; i++) cumB[i] = '0;
        m_lfsr = SEED;
        for (int i = 0; i < N; i++) exp_path[i] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_obs_out", obs_out, 0);
        check("reset_obs_valid", obs_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_path", pack_dut_path(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Deterministic chain 1->2->0->1->2 with identity emissions.
        set_chain();
        model_run(5);
        run(5, 0, 0);
        check_run("chain", 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("chain_const%0d", i), (i < got.size()) ? got[i] : -1, chain_exp[i]);
        check("chain_first_valid", first_v, 2);
        check("chain_done_latency", done_c, last_h + 1);

        // Backpressure on the second symbol.
        model_run(5);
        run(5, 2, 0);
        check_run("stall", 5);
        check("stall_cycles", stall_seen, 4);
        check("stall_held_obs", stall_obs, 2);

        // Zero length.
        model_run(0);
        run(0, 0, 0);
        check("len0_handshakes", n_hs, 0);
        check("len0_no_valid", first_v, -1);
        check("len0_done", done_c, 1);

        // Over-length request clips to N.
        set_uniform();
        model_run(20);
        run(20, 1, 0);
        check_run("len20", 20);

        // Shorter run keeps path entries beyond its length.
        model_run(5);
        run(5, 1, 0);
        check_run("short_keep", 5);

        // Reset reproducibility.
        do_reset();
        model_run(8);
        run(8, 0, 0);
        check_run("clean", 8);
        seq_a = got;
        do_reset();
        run(8, 0, 3);
        do_reset();
        model_run(8);
        run(8, 1, 0);
        check_run("rerun", 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("repro%0d", i), (i < got.size()) ? got[i] : -1, seq_a[i]);

        // Zero seed reloads the default seed.
        load_seed(32'd0);
        model_run(8);
        run(8, 1, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("seed0_%0d", i), (i < got.size()) ? got[i] : -1, seq_a[i]);

        // No qualifying initial threshold falls back to the last state.
        cumC = '{0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            model_run(3);
            run(3, 1, 0);
            check_run("fallback", 3);
            check("fallback_s0", state_path[0], 2);
        end

        // Randomized seeds, tables, lengths and ready patterns.
        for (int k = 0; k < 8; k++) begin
            int len;
            load_seed(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            rand_row(cumC[0], cumC[1], cumC[2]);
            for (int i = 0; i < I; i++) begin
                rand_row(cumA[i*3], cumA[i*3+1], cumA[i*3+2]);
                rand_row(cumB[i*3], cumB[i*3+1], cumB[i*3+2]);
            end
            len = $urandom_range(0, 20);
            model_run(len);
            run(len, 1, 0);
            check_run($sformatf("rand%0d", k), len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
